// File: rtl/scp_079_cmd_arbiter_if.sv
// scp_079_cmd_arbiter_if: request/command inputs and grant/colour outputs between requesters and the arbiter
interface scp_079_cmd_arbiter_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] cmd;
  logic                 scp_cheat;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 abort;
  logic                 green;
  logic                 yellow;
  logic                 red;
  logic                 busy;
  modport master (output req, cmd, scp_cheat, input gnt, done, abort, green, yellow, red, busy);
  modport slave (input req, cmd, scp_cheat, output gnt, done, abort, green, yellow, red, busy);
endinterface

// File: rtl/scp_079_cmd_arbiter.sv
// scp_079_cmd_arbiter: round-robin sharing of scp_079 colour commands with hold/gap timing and cheat abort.
// Optional SCP_ARB_RED_PRIORITY_EN: red (cmd=11) requesters win over all others in IDLE.
module scp_079_cmd_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input logic                  clock,
  input logic                  reset_n,
  scp_079_cmd_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr, rr_n, own, own_n, win;
  logic [5:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt, gnt_n, done, done_n, elig, pick;
  logic abort, abort_n, busy, busy_n, found;
  logic [2:0] col, col_n;
  logic [1:0] wcmd;
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) elig[i] = bus.req[i] && (bus.cmd[2*i +: 2] != 2'b00);
`ifdef SCP_ARB_RED_PRIORITY_EN
    pick = '0;
    for (int i = 0; i < NUM_REQ; i++) pick[i] = elig[i] && (bus.cmd[2*i +: 2] == 2'b11);
    pick = |pick ? pick : elig;
`else
    pick = elig;
`endif
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && pick[(int'(rr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = IW'((int'(rr) + k) % NUM_REQ);
      end
    wcmd = bus.cmd[2*int'(win) +: 2];
  end
  // col holds the latched command as {red, yellow, green}, so later cmd changes are ignored
  always_comb begin
    state_n = state;
    rr_n = rr;
    own_n = own;
    cnt_n = cnt;
    gnt_n = gnt;
    col_n = col;
    busy_n = busy;
    done_n = '0;
    abort_n = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_n = HOLD;
        own_n = win;
        gnt_n = NUM_REQ'(1) << win;
        col_n = {wcmd == 2'b11, wcmd == 2'b10, wcmd == 2'b01};
        busy_n = 1'b1;
        cnt_n = 6'(HOLD_CYCLES - 1);
        rr_n = IW'((int'(win) + 1) % NUM_REQ);
      end
      HOLD: if (bus.scp_cheat || !bus.req[own] || cnt == 6'd0) begin
        abort_n = bus.scp_cheat;
        done_n = (!bus.scp_cheat && bus.req[own]) ? gnt : '0;
        gnt_n = '0;
        col_n = '0;
        state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        busy_n = (GAP_CYCLES != 0);
        cnt_n = 6'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
      end else cnt_n = cnt - 6'd1;
      GAP: if (cnt == 6'd0) begin
        state_n = IDLE;
        busy_n = 1'b0;
      end else cnt_n = cnt - 6'd1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rr <= '0;
      own <= '0;
      cnt <= '0;
      gnt <= '0;
      done <= '0;
      abort <= 1'b0;
      busy <= 1'b0;
      col <= '0;
    end else begin
      state <= state_n;
      rr <= rr_n;
      own <= own_n;
      cnt <= cnt_n;
      gnt <= gnt_n;
      done <= done_n;
      abort <= abort_n;
      busy <= busy_n;
      col <= col_n;
    end
  assign bus.gnt = gnt;
  assign bus.done = done;
  assign bus.abort = abort;
  assign bus.busy = busy;
  assign {bus.red, bus.yellow, bus.green} = col;
endmodule

// File: tb/tb_scp_079_cmd_arbiter.sv
// tb_scp_079_cmd_arbiter: directed checks of grant timing, round-robin order, abort, early release and reset.
module tb_scp_079_cmd_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  scp_079_cmd_arbiter_if #(.NUM_REQ(3)) bus ();
  scp_079_cmd_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  logic [2:0] rr_exp [4];
  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    bus.req = '0; bus.cmd = '0; bus.scp_cheat = 1'b0;
    #3;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_col", 32'({bus.red, bus.yellow, bus.green}), 0);
    step(2);
    reset_n = 1'b1;
    // basic green grant: 8 edges high, done, 2-edge gap
    bus.req = 3'b001; bus.cmd = 6'b000001;
    step(1);
    check("g_gnt", 32'(bus.gnt), 32'b001);
    check("g_green", 32'(bus.green), 1);
    check("g_busy", 32'(bus.busy), 1);
    for (int i = 2; i <= 8; i++) begin
      step(1);
      check($sformatf("g_hold%0d", i), 32'({bus.gnt, bus.green, bus.done}), 32'b001_1_000);
    end
    step(1);
    check("g_end", 32'({bus.gnt, bus.green, bus.done, bus.busy}), 32'b000_0_001_1);
    step(1);
    check("g_gap", 32'({bus.gnt, bus.done, bus.busy}), 32'b000_000_1);
    step(1);
    check("g_idle", 32'({bus.gnt, bus.busy}), 32'b000_0);
    step(1);
    check("g_regnt", 32'(bus.gnt), 32'b001);
    bus.req = 3'b000;
    step(1);
    check("g_rel", 32'({bus.gnt, bus.done, bus.busy}), 32'b000_000_1);
    step(2);
    check("g_rel_idle", 32'(bus.busy), 0);
    // async reset mid-HOLD
    bus.req = 3'b001;
    step(2);
    check("r_gnt", 32'(bus.gnt), 32'b001);
    #2 reset_n = 1'b0;
    #1;
    check("r_async", 32'({bus.gnt, bus.green, bus.busy}), 0);
    bus.req = 3'b000;
    step(1);
    reset_n = 1'b1;
    // round robin with yellow, rr starts at 0
    bus.req = 3'b111; bus.cmd = 6'b101010;
    step(1);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr_gnt%0d", j), 32'(bus.gnt), 32'(rr_exp[j]));
      check($sformatf("rr_yel%0d", j), 32'(bus.yellow), 1);
      step(8);
      check($sformatf("rr_done%0d", j), 32'({bus.done, bus.yellow, bus.gnt}), 32'({rr_exp[j], 1'b0, 3'b000}));
      step(1);
      check($sformatf("rr_gap%0d", j), 32'({bus.yellow, bus.busy}), 32'b01);
      step(1);
      check($sformatf("rr_idle%0d", j), 32'({bus.yellow, bus.busy, bus.gnt}), 0);
      if (j == 3) bus.req = 3'b000;
      step(1);
    end
    // cheat abort on 3rd HOLD edge
    bus.req = 3'b001; bus.cmd = 6'b000011;
    step(1);
    check("a_red", 32'({bus.gnt, bus.red}), 32'b001_1);
    step(2);
    bus.scp_cheat = 1'b1;
    step(1);
    check("a_abort", 32'({bus.abort, bus.red, bus.gnt, bus.done, bus.busy}), 32'b1_0_000_000_1);
    bus.scp_cheat = 1'b0;
    step(1);
    check("a_pulse", 32'({bus.abort, bus.done}), 0);
    step(1);
    check("a_idle", 32'(bus.busy), 0);
    bus.req = 3'b000;
    // invalid command never granted; cheat in idle ignored
    bus.req = 3'b010; bus.cmd = 6'b000000; bus.scp_cheat = 1'b1;
    step(3);
    check("inv_gnt", 32'({bus.gnt, bus.busy, bus.abort}), 0);
    bus.scp_cheat = 1'b0;
    // owner drops request on 4th HOLD edge
    bus.cmd = 6'b000100;
    step(1);
    check("e_gnt", 32'({bus.gnt, bus.green}), 32'b010_1);
    step(3);
    check("e_still", 32'(bus.gnt), 32'b010);
    bus.req = 3'b000;
    step(1);
    check("e_rel", 32'({bus.gnt, bus.green, bus.done, bus.busy}), 32'b000_0_000_1);
    step(2);
    check("e_idle", 32'(bus.busy), 0);
    // red priority selection from rr=0
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    bus.req = 3'b011; bus.cmd = 6'b001101;
    step(1);
`ifdef SCP_ARB_RED_PRIORITY_EN
    check("p_sel", 32'({bus.gnt, bus.red, bus.green}), 32'b010_1_0);
`else
    check("p_sel", 32'({bus.gnt, bus.red, bus.green}), 32'b001_0_1);
`endif
    bus.req = 3'b000;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
